sandbox_command_sequencer: RTL and testbench

- Sequences the 48-bit UART frame interface on behalf of the sandbox process.
- Accepts a received command frame, acknowledges it, and either answers it internally or dispatches it to the device under test (DUT) with a start/done handshake and a timeout.
- Builds a 48-bit response frame and drives the transmit handshake until the frame has been sent.
- Sits between the wide UART I/O block and the DUT.

---
 rtl/sandbox_command_sequencer_if.sv | 35 +++
 rtl/sandbox_command_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_sandbox_command_sequencer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sandbox_command_sequencer_if.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | sandbox_command_sequencer_if: UART frame and DUT handshake bundle   |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
interface sandbox_command_sequencer_if;
  logic        dataReceived;
  logic [47:0] inputData;
  logic        clearDR;
  logic        transmitting;
  logic        transmit;
  logic [47:0] outputData;
  logic        dutStart;
  logic        dutAbort;
  logic [7:0]  dutOpcode;
  logic [31:0] dutArgument;
  logic        dutDone;
  logic        dutError;
  logic [31:0] dutResult;
  logic        busy;
  logic        txFault;

  modport master (
    input  dataReceived, inputData, transmitting, dutDone, dutError, dutResult,
    output clearDR, transmit, outputData, dutStart, dutAbort, dutOpcode,
           dutArgument, busy, txFault
  );

  modport slave (
    output dataReceived, inputData, transmitting, dutDone, dutError, dutResult,
    input  clearDR, transmit, outputData, dutStart, dutAbort, dutOpcode,
           dutArgument, busy, txFault
  );
endinterface
`default_nettype wire

// File: rtl/sandbox_command_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | sandbox_command_sequencer: UART command frame -> DUT -> response    |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
module sandbox_command_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 12000000,
  parameter int unsigned TX_WAIT_CYCLES = 64,
  parameter logic [7:0]  MAX_OPCODE     = 8'h0F
) (
  input wire                          masterClock,
  input wire                          reset,
  sandbox_command_sequencer_if.master bus
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int TX_W = $clog2(TX_WAIT_CYCLES) + 1;
  localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TX_W-1:0] c_tx_last = TX_W'(TX_WAIT_CYCLES);
  localparam logic [7:0] c_st_ok      = 8'h00;
  localparam logic [7:0] c_st_dut_err = 8'h01;
  localparam logic [7:0] c_st_illegal = 8'h02;
  localparam logic [7:0] c_st_timeout = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_DECODE   = 3'd2,
    S_DISPATCH = 3'd3,
    S_WAIT_DUT = 3'd4,
    S_LOAD     = 3'd5,
    S_TX_START = 3'd6,
    S_TX_WAIT  = 3'd7
  } state_t;

  state_t          r_state,    w_state;
  logic            r_clear,    w_clear;
  logic            r_transmit, w_transmit;
  logic [47:0]     r_out_data, w_out_data;
  logic            r_start,    w_start;
  logic            r_abort,    w_abort;
  logic [7:0]      r_opcode,   w_opcode;
  logic [7:0]      r_tag,      w_tag;
  logic [31:0]     r_arg,      w_arg;
  logic [7:0]      r_status,   w_status;
  logic [31:0]     r_result,   w_result;
  logic            r_busy,     w_busy;
  logic            r_tx_fault, w_tx_fault;
  logic [TO_W-1:0] r_to_cnt,   w_to_cnt;
  logic [TX_W-1:0] r_tx_cnt,   w_tx_cnt;
  logic [TO_W-1:0] w_to_inc;
  logic [TX_W-1:0] w_tx_inc;

  assign w_to_inc = r_to_cnt + TO_W'(1);
  assign w_tx_inc = r_tx_cnt + TX_W'(1);

  // Next values of every registered output are computed here, so all outputs leave flops.
  always_comb begin
    w_state    = r_state;
    w_clear    = r_clear;
    w_transmit = r_transmit;
    w_out_data = r_out_data;
    w_start    = 1'b0;
    w_abort    = 1'b0;
    w_opcode   = r_opcode;
    w_tag      = r_tag;
    w_arg      = r_arg;
    w_status   = r_status;
    w_result   = r_result;
    w_tx_fault = r_tx_fault;
    w_to_cnt   = r_to_cnt;
    w_tx_cnt   = r_tx_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.dataReceived) begin
          w_opcode = bus.inputData[47:40];
          w_tag    = bus.inputData[39:32];
          w_arg    = bus.inputData[31:0];
          w_clear  = 1'b1;
          w_state  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (!bus.dataReceived) begin
          w_clear = 1'b0;
          w_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (r_opcode == 8'h00) begin
          w_status = c_st_ok;
          w_result = r_arg;
          w_state  = S_LOAD;
        end else if (r_opcode > MAX_OPCODE) begin
          w_status = c_st_illegal;
          w_result = 32'h0;
          w_state  = S_LOAD;
        end else begin
          w_start  = 1'b1;
          w_to_cnt = '0;
          w_state  = S_DISPATCH;
        end
      end
      S_DISPATCH: w_state = S_WAIT_DUT;
      S_WAIT_DUT: begin
        // A completion seen on the timeout cycle takes priority over the abort.
        if (bus.dutDone) begin
          w_result = bus.dutResult;
          w_status = bus.dutError ? c_st_dut_err : c_st_ok;
          w_state  = S_LOAD;
        end else if (w_to_inc == c_to_last) begin
          w_abort  = 1'b1;
          w_status = c_st_timeout;
          w_result = 32'h0;
          w_state  = S_LOAD;
        end else begin
          w_to_cnt = w_to_inc;
        end
      end
      S_LOAD: begin
        w_out_data = {r_status, r_tag, r_result};
        w_transmit = 1'b1;
        w_tx_cnt   = '0;
        w_state    = S_TX_START;
      end
      S_TX_START: begin
        if (bus.transmitting) begin
          w_transmit = 1'b0;
          w_state    = S_TX_WAIT;
        end else if (w_tx_inc == c_tx_last) begin
          w_transmit = 1'b0;
          w_tx_fault = 1'b1;
          w_state    = S_IDLE;
        end else begin
          w_tx_cnt = w_tx_inc;
        end
      end
      S_TX_WAIT: begin
        if (!bus.transmitting) w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_clear    <= 1'b0;
      r_transmit <= 1'b0;
      r_out_data <= 48'h0;
      r_start    <= 1'b0;
      r_abort    <= 1'b0;
      r_opcode   <= 8'h0;
      r_tag      <= 8'h0;
      r_arg      <= 32'h0;
      r_status   <= 8'h0;
      r_result   <= 32'h0;
      r_busy     <= 1'b0;
      r_tx_fault <= 1'b0;
      r_to_cnt   <= '0;
      r_tx_cnt   <= '0;
    end else begin
      r_state    <= w_state;
      r_clear    <= w_clear;
      r_transmit <= w_transmit;
      r_out_data <= w_out_data;
      r_start    <= w_start;
      r_abort    <= w_abort;
      r_opcode   <= w_opcode;
      r_tag      <= w_tag;
      r_arg      <= w_arg;
      r_status   <= w_status;
      r_result   <= w_result;
      r_busy     <= w_busy;
      r_tx_fault <= w_tx_fault;
      r_to_cnt   <= w_to_cnt;
      r_tx_cnt   <= w_tx_cnt;
    end
  end

  assign bus.clearDR     = r_clear;
  assign bus.transmit    = r_transmit;
  assign bus.outputData  = r_out_data;
  assign bus.dutStart    = r_start;
  assign bus.dutAbort    = r_abort;
  assign bus.dutOpcode   = r_opcode;
  assign bus.dutArgument = r_arg;
  assign bus.busy        = r_busy;
  assign bus.txFault     = r_tx_fault;

endmodule
`default_nettype wire

// File: tb/tb_sandbox_command_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | tb_sandbox_command_sequencer: scoreboard bench with UART/DUT models |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
module tb_sandbox_command_sequencer;

  localparam int          TIMEOUT = 16;
  localparam int          TXW     = 8;
  localparam logic [7:0]  MAX_OP  = 8'h0F;

  typedef struct {
    logic [47:0] frame;
    bit          chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_start = 0;
  int   n_abort = 0;
  int   start_cyc = 0;
  int   last_clr_fall = 0;
  int   last_tx_rise = 0;
  int   last_tx_fall = 0;
  exp_t exp_q[$];

  int          resp_delay = -1;
  logic [31:0] resp_result = 32'h0;
  bit          resp_err = 1'b0;
  logic [7:0]  cur_op = 8'h0;
  logic [31:0] cur_arg = 32'h0;
  bit          tx_stall = 1'b0;

  sandbox_command_sequencer_if sif();

  sandbox_command_sequencer #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .TX_WAIT_CYCLES(TXW),
    .MAX_OPCODE    (MAX_OP)
  ) dut (
    .masterClock(clk),
    .reset      (rst_n),
    .bus        (sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tmo(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got timeout, expected event (cycle %0d)", name, cyc);
  endtask

  // Reference response built straight from the command rules.
  function automatic logic [47:0] model(input logic [7:0] op, input logic [7:0] tag,
                                        input logic [31:0] arg, input int delay,
                                        input logic [31:0] res, input bit err);
    if (op == 8'h00) return {8'h00, tag, arg};
    if (op > MAX_OP) return {8'h02, tag, 32'h0};
    if (delay >= 1 && delay <= TIMEOUT - 1) return {(err ? 8'h01 : 8'h00), tag, res};
    return {8'h03, tag, 32'h0};
  endfunction

  task automatic accept_frame();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sif.clearDR) begin ok = 1'b1; break; end
    end
    if (!ok) tmo("clearDR rise");
    repeat ($urandom_range(0, 2)) @(negedge clk);
    check("clearDR held while dataReceived", sif.clearDR, 1);
    sif.dataReceived = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!sif.busy) begin ok = 1'b1; break; end
    end
    if (!ok) tmo("busy fall");
    @(negedge clk);
  endtask

  task automatic do_cmd(input logic [7:0] op, input logic [7:0] tag, input logic [31:0] arg,
                        input int delay, input logic [31:0] res, input bit err);
    exp_t e;
    int   s0, a0;
    bit   legal;
    legal = (op != 8'h00) && (op <= MAX_OP);
    resp_delay = delay; resp_result = res; resp_err = err;
    cur_op = op; cur_arg = arg;
    e.frame = model(op, tag, arg, delay, res, err);
    e.chk_lat = !legal;
    exp_q.push_back(e);
    s0 = n_start; a0 = n_abort;
    sif.inputData = {op, tag, arg};
    sif.dataReceived = 1'b1;
    accept_frame();
    wait_idle();
    check("dutStart count", n_start - s0, legal ? 1 : 0);
    check("dutAbort count", n_abort - a0, (legal && (delay < 1 || delay > TIMEOUT - 1)) ? 1 : 0);
  endtask

  // DUT model: answers each dutStart after resp_delay cycles (never when negative).
  initial begin
    sif.dutDone = 1'b0; sif.dutError = 1'b0; sif.dutResult = 32'h0;
    forever begin
      @(negedge clk);
      if (sif.dutStart) begin
        n_start++;
        start_cyc = cyc;
        check("dutOpcode/dutArgument", {sif.dutOpcode, sif.dutArgument}, {cur_op, cur_arg});
        if (resp_delay > 0) begin
          repeat (resp_delay) @(negedge clk);
          sif.dutResult = resp_result; sif.dutError = resp_err; sif.dutDone = 1'b1;
          @(negedge clk);
          sif.dutDone = 1'b0; sif.dutResult = $urandom; sif.dutError = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (sif.dutAbort) begin
        n_abort++;
        check("dutAbort delay after dutStart", cyc - start_cyc, TIMEOUT);
      end
    end
  end

  // UART transmitter model.
  initial begin
    sif.transmitting = 1'b0;
    forever begin
      @(negedge clk);
      if (sif.transmit && !tx_stall) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        sif.transmitting = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        sif.transmitting = 1'b0;
      end
    end
  end

  // Scoreboard monitor: pops an expectation on every transmit request.
  initial begin
    bit   p_tx, p_clr;
    exp_t e;
    p_tx = 1'b0; p_clr = 1'b0;
    forever begin
      @(negedge clk);
      if (p_clr && !sif.clearDR) last_clr_fall = cyc;
      if (!p_tx && sif.transmit) begin
        last_tx_rise = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected transmit: got outputData %0h, expected no frame", sif.outputData);
        end else begin
          e = exp_q.pop_front();
          check("outputData", sif.outputData, e.frame);
          if (e.chk_lat) check("transmit latency after clearDR fall", cyc - last_clr_fall, 2);
        end
      end
      if (p_tx && !sif.transmit) last_tx_fall = cyc;
      p_tx = sif.transmit; p_clr = sif.clearDR;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected $finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   s0, a0, early;
    bit   ok;
    logic [7:0] op;
    int   cat, dly;
    sif.dataReceived = 1'b0;
    sif.inputData = 48'h0;

    repeat (3) @(negedge clk);
    check("outputs in reset", {sif.clearDR, sif.transmit, sif.outputData, sif.dutStart, sif.dutAbort,
          sif.dutOpcode, sif.dutArgument, sif.busy, sif.txFault}, 96'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("busy idle after reset", sif.busy, 0);

    do_cmd(8'h00, 8'h7A, 32'hDEADBEEF, -1, 32'h0, 1'b0);
    do_cmd(8'h03, 8'h11, 32'h1, 10, 32'hCAFE0001, 1'b0);
    do_cmd(8'h03, 8'h11, 32'h1, 10, 32'hCAFE0001, 1'b1);
    do_cmd(8'h20, 8'h22, 32'h12345678, -1, 32'h0, 1'b0);
    do_cmd(8'h0F, 8'h33, 32'h5, -1, 32'h0, 1'b0);
    do_cmd(8'h05, 8'h44, 32'h6, TIMEOUT - 1, 32'hA5A5A5A5, 1'b0);
    do_cmd(8'h05, 8'h45, 32'h7, TIMEOUT, 32'h5A5A5A5A, 1'b0);
    do_cmd(8'h10, 8'h46, 32'h8, -1, 32'h0, 1'b0);

    tx_stall = 1'b1;
    do_cmd(8'h00, 8'h55, 32'h0BADF00D, -1, 32'h0, 1'b0);
    check("transmit high time on stall", last_tx_fall - last_tx_rise, TXW);
    check("txFault after stall", sif.txFault, 1);
    tx_stall = 1'b0;
    do_cmd(8'h00, 8'h56, 32'h600DF00D, -1, 32'h0, 1'b0);
    check("txFault sticky", sif.txFault, 1);

    // Second frame offered while the first is still waiting on the DUT.
    resp_delay = 12; resp_result = 32'h13572468; resp_err = 1'b0;
    cur_op = 8'h04; cur_arg = 32'hAAAA5555;
    e.frame = model(8'h04, 8'h61, 32'hAAAA5555, 12, 32'h13572468, 1'b0); e.chk_lat = 1'b0;
    exp_q.push_back(e);
    s0 = n_start;
    sif.inputData = {8'h04, 8'h61, 32'hAAAA5555};
    sif.dataReceived = 1'b1;
    accept_frame();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (n_start > s0) begin ok = 1'b1; break; end
    end
    if (!ok) tmo("dutStart for back-pressure frame");
    e.frame = model(8'h00, 8'h62, 32'h00C0FFEE, -1, 32'h0, 1'b0); e.chk_lat = 1'b1;
    exp_q.push_back(e);
    sif.inputData = {8'h00, 8'h62, 32'h00C0FFEE};
    sif.dataReceived = 1'b1;
    early = 0; ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sif.clearDR) early++;
      if (!sif.busy) begin ok = 1'b1; break; end
    end
    if (!ok) tmo("busy fall with pending frame");
    check("no clearDR while busy", early, 0);
    accept_frame();
    wait_idle();

    for (int k = 0; k < 40; k++) begin
      cat = $urandom_range(0, 3);
      if (cat == 0)      op = 8'h00;
      else if (cat == 1) op = 8'($urandom_range(16, 255));
      else               op = 8'($urandom_range(1, 15));
      dly = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, TIMEOUT + 3));
      do_cmd(op, 8'($urandom), $urandom, dly, $urandom, 1'($urandom_range(0, 1)));
    end

    // Reset while waiting on the DUT: outputs clear at once, no abort.
    resp_delay = -1; cur_op = 8'h06; cur_arg = 32'h76543210;
    s0 = n_start; a0 = n_abort;
    sif.inputData = {8'h06, 8'h77, 32'h76543210};
    sif.dataReceived = 1'b1;
    accept_frame();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (n_start > s0) begin ok = 1'b1; break; end
    end
    if (!ok) tmo("dutStart before reset");
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("outputs immediately in reset", {sif.clearDR, sif.transmit, sif.outputData, sif.dutStart,
          sif.dutAbort, sif.dutOpcode, sif.dutArgument, sif.busy, sif.txFault}, 96'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (TIMEOUT + 5) @(negedge clk);
    check("no dutAbort across reset", n_abort - a0, 0);
    check("idle after reset release", {sif.busy, sif.transmit, sif.txFault}, 0);

    do_cmd(8'h00, 8'h88, 32'hFEEDFACE, -1, 32'h0, 1'b0);
    repeat (5) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
